mp_mult_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-lane 17-bit multiplier array in the mixed-precision MAC datapath of the extended Ibex core.
- NUM_LANES independent lanes. Each lane does either one full-width signed multiply, or a packed sub-word dot product (2x8, 4x4 or 8x2 bit) reduced to one lane result.
- Valid/ready handshakes on both sides and a fixed-latency elastic pipeline; sits between the operand-fetch stage and the partial-product adder tree.

---
 rtl/mp_mult_pkg.sv | 22 ++
 rtl/mp_mult_lane.sv | 59 +++++
 rtl/mp_mult_pipe.sv | 124 ++++++++++++
 tb/tb_mp_mult_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_mult_pkg.sv
// Shared mode encoding and sub-word geometry for the mixed-precision multiplier pipeline.
package mp_mult_pkg;

    typedef enum logic [1:0] {
        MP_FULL = 2'b00,
        MP_2X8  = 2'b01,
        MP_4X4  = 2'b10,
        MP_8X2  = 2'b11
    } mp_mode_e;

    localparam int DATA_W = 16;

    function automatic int mp_sub_cnt(input mp_mode_e mode);
        case (mode)
            MP_2X8:  return 2;
            MP_4X4:  return 4;
            MP_8X2:  return 8;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/mp_mult_lane.sv
// One multiplier lane: full-width signed multiply or packed sub-word dot product.
// Purely combinational (latency 0); no flow control of its own.
module mp_mult_lane
    import mp_mult_pkg::*;
#(
    parameter int OP_W = 17
) (
    input  mp_mode_e          mode_i,
    input  logic              act_signed_i,
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [2*OP_W-1:0] res_o
);

    localparam int RES_W = 2 * OP_W;

    logic signed [OP_W-1:0]  a_s;
    logic signed [OP_W-1:0]  b_s;
    logic signed [RES_W-1:0] full;

    assign a_s  = a_i;
    assign b_s  = b_i;
    assign full = a_s * b_s;

    // Each sub-word is widened by one bit so signed weights and signed or
    // unsigned activations share a single signed multiplier.
    for (genvar g = 1; g < 4; g++) begin : g_dot
        localparam int K = mp_sub_cnt(mp_mode_e'(g));
        localparam int W = DATA_W / K;

        logic signed [RES_W-1:0] dot;

        always_comb begin
            logic signed [W:0]     wt;
            logic signed [W:0]     ac;
            logic signed [2*W+1:0] prod;
            wt   = '0;
            ac   = '0;
            prod = '0;
            dot  = '0;
            for (int j = 0; j < K; j++) begin
                wt   = {a_i[W*j+W-1], a_i[W*j +: W]};
                ac   = {act_signed_i & b_i[W*j+W-1], b_i[W*j +: W]};
                prod = wt * ac;
                dot  = dot + {{(RES_W-2*W-2){prod[2*W+1]}}, prod};
            end
        end
    end

    always_comb begin
        case (mode_i)
            MP_2X8:  res_o = g_dot[1].dot;
            MP_4X4:  res_o = g_dot[2].dot;
            MP_8X2:  res_o = g_dot[3].dot;
            default: res_o = full;
        endcase
    end

endmodule

// File: rtl/mp_mult_pipe.sv
// NUM_LANES-wide multiplier pipeline, fixed latency PIPE_STAGES; global stall when output is held.
// Optional MP_MULT_PERF_CNT_EN adds op/stall counters.
module mp_mult_pipe
    import mp_mult_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int OP_W        = 17,
    parameter int PIPE_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [1:0]                    mode_i,
    input  logic                          act_signed_i,
    input  logic [NUM_LANES*OP_W-1:0]     weight_vals_i,
    input  logic [NUM_LANES*OP_W-1:0]     activations_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NUM_LANES*2*OP_W-1:0]   partial_prods_o
`ifdef MP_MULT_PERF_CNT_EN
    ,
    output logic [31:0]                   op_cnt_o,
    output logic [31:0]                   stall_cnt_o
`endif
);

    localparam int RES_W = 2 * OP_W;
    localparam int BUS_W = NUM_LANES * RES_W;

    logic                   adv;
    logic                   accept;
    logic [BUS_W-1:0]       lane_res;

    logic [PIPE_STAGES-1:0] vld_q, vld_d;
    logic [BUS_W-1:0]       res_q [PIPE_STAGES];
    logic [BUS_W-1:0]       res_d [PIPE_STAGES];

    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    // Results are formed at the input, so mode and signedness travel with the data.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mp_mult_lane #(
            .OP_W (OP_W)
        ) u_lane (
            .mode_i       (mp_mode_e'(mode_i)),
            .act_signed_i (act_signed_i),
            .a_i          (weight_vals_i[l*OP_W +: OP_W]),
            .b_i          (activations_i[l*OP_W +: OP_W]),
            .res_o        (lane_res[l*RES_W +: RES_W])
        );
    end

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            res_d[i] = res_q[i];
        end
        if (adv) begin
            vld_d[0] = accept;
            if (accept) begin
                res_d[0] = lane_res;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                res_d[i] = res_q[i-1];
            end
        end
        // Flush wins over everything, including a stalled output.
        if (flush_i) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                res_q[i] <= res_d[i];
            end
        end
    end

    assign out_valid_o     = vld_q[PIPE_STAGES-1];
    assign partial_prods_o = res_q[PIPE_STAGES-1];

`ifdef MP_MULT_PERF_CNT_EN
    logic [31:0] op_cnt_q, op_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        op_cnt_d    = op_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && out_ready_i) begin
            op_cnt_d = op_cnt_q + 32'd1;
        end
        if (out_valid_o && !out_ready_i) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            op_cnt_q    <= op_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign op_cnt_o    = op_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mp_mult_pipe.sv
// Scoreboard bench for mp_mult_pipe: directed vectors, stall, flush, reset and random traffic.
module tb_mp_mult_pipe;

    localparam int NL = 4;
    localparam int OW = 17;
    localparam int PS = 2;
    localparam int IW = NL * OW;
    localparam int BW = NL * 2 * OW;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic          act_signed;
    logic [IW-1:0] wts;
    logic [IW-1:0] acts;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] pp;
`ifdef MP_MULT_PERF_CNT_EN
    logic [31:0]   op_cnt;
    logic [31:0]   stall_cnt;
`endif

    int n_checks  = 0;
    int n_errors  = 0;
    int tb_ops    = 0;
    int tb_stalls = 0;
    logic [BW-1:0] exp_q [$];

    mp_mult_pipe #(
        .NUM_LANES   (NL),
        .OP_W        (OW),
        .PIPE_STAGES (PS)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .mode_i          (mode),
        .act_signed_i    (act_signed),
        .weight_vals_i   (wts),
        .activations_i   (acts),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .partial_prods_o (pp)
`ifdef MP_MULT_PERF_CNT_EN
        ,
        .op_cnt_o        (op_cnt),
        .stall_cnt_o     (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*OW-1:0] model_lane(input logic [1:0] m, input logic sg,
                                                   input logic [OW-1:0] w, input logic [OW-1:0] a);
        longint      acc;
        int          wd, mask, wv, av;
        logic [OW-1:0] sw, sa;
        logic [63:0] r;
        acc = 0;
        if (m == 2'b00) begin
            acc = longint'($signed(w)) * longint'($signed(a));
        end else begin
            wd   = (m == 2'b01) ? 8 : (m == 2'b10) ? 4 : 2;
            mask = (1 << wd) - 1;
            for (int j = 0; j < 16 / wd; j++) begin
                sw = w >> (j * wd);
                sa = a >> (j * wd);
                wv = int'(sw) & mask;
                av = int'(sa) & mask;
                if (wv >= (1 << (wd - 1))) wv -= (1 << wd);
                if (sg && av >= (1 << (wd - 1))) av -= (1 << wd);
                acc += longint'(wv * av);
            end
        end
        r = acc;
        return r[2*OW-1:0];
    endfunction

    function automatic logic [BW-1:0] model(input logic [1:0] m, input logic sg,
                                            input logic [IW-1:0] w, input logic [IW-1:0] a);
        logic [BW-1:0] res;
        for (int l = 0; l < NL; l++) begin
            res[l*2*OW +: 2*OW] = model_lane(m, sg, w[l*OW +: OW], a[l*OW +: OW]);
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] rand_bus();
        logic [IW-1:0] b;
        for (int l = 0; l < NL; l++) begin
            b[l*OW +: OW] = OW'($urandom);
        end
        return b;
    endfunction

    // Holds in_valid until accepted; inputs only change 1 time unit after a rising edge.
    task automatic send(input logic [1:0] m, input logic sg, input logic [IW-1:0] w, input logic [IW-1:0] a);
        int t;
        t          = 0;
        mode       = m;
        act_signed = sg;
        wts        = w;
        acts       = a;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(model(m, sg, w, a));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        send(2'($urandom), 1'($urandom), rand_bus(), rand_bus());
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(tag, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            tb_ops    = 0;
            tb_stalls = 0;
        end else begin
            if (out_valid && !out_ready) tb_stalls++;
            if (out_valid && out_ready) begin
                tb_ops++;
                if (exp_q.size() == 0) check("unexpected_out", 1, 0);
                else check("result", pp, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [IW-1:0] w, a;
        int n;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        mode       = 2'b00;
        act_signed = 1'b0;
        wts        = '0;
        acts       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", out_valid, 0);
        check("rst_pp", pp, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-width multiply and first-result latency
        w = rand_bus(); w[OW-1:0] = 17'h1FFFD;
        a = rand_bus(); a[OW-1:0] = 17'h00005;
        send(2'b00, 1'b0, w, a);
        in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, PS);
        check("m00_lane0", pp[2*OW-1:0], 34'h3FFFFFFF1);
        @(posedge clk);
        #1;

        // Sub-word modes; bit 16 of the mode-01 weight must be ignored
        w = rand_bus(); w[OW-1:0] = 17'h10203;
        a = rand_bus(); a[OW-1:0] = 17'h00405;
        send(2'b01, 1'b1, w, a);
        w = rand_bus(); w[OW-1:0] = 17'h0FFFF;
        a = rand_bus(); a[OW-1:0] = 17'h01111;
        send(2'b10, 1'b1, w, a);
        w = rand_bus(); w[OW-1:0] = 17'h05555;
        a = rand_bus(); a[OW-1:0] = 17'h0FFFF;
        send(2'b11, 1'b0, w, a);
        send(2'b11, 1'b1, w, a);
        in_valid = 1'b0;
        drain("drain_modes");

        // Back-to-back traffic against a 5-cycle output stall
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_rand();
                in_valid = 1'b0;
            end
            begin
                int t;
                logic [BW-1:0] held;
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                check("stall_vld", out_valid, 1);
                held = pp;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_hold", pp, held);
                    check("stall_inrdy", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("burst_vld", out_valid, 1);
                end
            end
        join
        drain("drain_stall");

        // Flush with two ops in flight and a competing input offer
        out_ready = 1'b0;
        send_rand();
        send_rand();
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_inrdy", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_vld", out_valid, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("flush_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send_rand();
        in_valid = 1'b0;
        drain("drain_flush");

        // Flush coinciding with an output handshake: that result is consumed
        send_rand();
        send_rand();
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_hs_left", exp_q.size(), 1);
        exp_q.delete();
        check("flush_hs_vld", out_valid, 0);

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send_rand();
                    if ($urandom_range(2) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 200; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_rand");

`ifdef MP_MULT_PERF_CNT_EN
        check("op_cnt", op_cnt, tb_ops);
        check("stall_cnt", stall_cnt, tb_stalls);
`endif

        // Asynchronous reset with a valid result at the output
        out_ready = 1'b0;
        send_rand();
        send_rand();
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_vld", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_vld", out_valid, 0);
        check("arst_pp", pp, 0);
`ifdef MP_MULT_PERF_CNT_EN
        check("arst_op_cnt", op_cnt, 0);
        check("arst_stall_cnt", stall_cnt, 0);
`endif
        exp_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send_rand();
        in_valid = 1'b0;
        drain("drain_post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
